eeg_p300_synth: RTL and testbench

- **Role:** synthetic P300 waveform generator, the transmit-side counterpart of the on-chip P300 detector.
- **Behaviour:** on a trigger it emits an 8-bit EEG sample stream in four phases: baseline latency, linear rise, peak hold, linear decay back to baseline.
- **Placement:** drives the detector's `eeg_signal` input in closed-loop benches and in the FPGA self-test path.

---
 rtl/eeg_pkg.sv | 39 +++
 rtl/eeg_p300_synth_if.sv | 18 +
 rtl/eeg_sample_tick.sv | 31 +++
 rtl/eeg_p300_synth.sv | 122 ++++++++++++
 tb/tb_eeg_p300_synth.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/eeg_pkg.sv
// Shared definitions for the synthetic P300 generator and the P300 detector:
// FSM state encoding, default signal levels and saturating ramp helpers.
package eeg_pkg;

    localparam logic [2:0] ST_IDLE_ENC = 3'd0;
    localparam logic [2:0] ST_LAT_ENC  = 3'd1;
    localparam logic [2:0] ST_RISE_ENC = 3'd2;
    localparam logic [2:0] ST_HOLD_ENC = 3'd3;
    localparam logic [2:0] ST_FALL_ENC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_LAT  = ST_LAT_ENC,
        ST_RISE = ST_RISE_ENC,
        ST_HOLD = ST_HOLD_ENC,
        ST_FALL = ST_FALL_ENC
    } state_e;

    localparam int BASELINE_DEF = 50;
    localparam int RISE_THR     = 70;
    localparam int FALL_THR     = 60;
    localparam int DET_TIMEOUT  = 300;

    // 9-bit intermediates keep the ramp from wrapping past either rail.
    function automatic logic [7:0] sat_add(input logic [7:0] v, input logic [8:0] step,
                                           input logic [7:0] ceil);
        logic [8:0] s;
        s = {1'b0, v} + step;
        return (s >= {1'b0, ceil}) ? ceil : s[7:0];
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] v, input logic [8:0] step,
                                           input logic [7:0] floor_v);
        logic [8:0] d;
        d = {1'b0, v} - step;
        return (d[8] || (d[7:0] < floor_v)) ? floor_v : d[7:0];
    endfunction

endpackage

// File: rtl/eeg_p300_synth_if.sv
// Trigger / sample-stream bundle between the P300 generator and its consumer.
interface eeg_p300_synth_if;
    logic       trigger;
    logic [7:0] eeg_signal;
    logic       sample_valid;
    logic       busy;
    logic       done;

    modport master (
        output trigger,
        input  eeg_signal, sample_valid, busy, done
    );

    modport slave (
        input  trigger,
        output eeg_signal, sample_valid, busy, done
    );
endinterface

// File: rtl/eeg_sample_tick.sv
// Free-running sample-rate divider; tick is high while the count sits at DIV-1.
module eeg_sample_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q, count_d;

    assign tick = (count_q == LAST);

    always_comb begin
        count_d = count_q + CW'(1);
        if (clr || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/eeg_p300_synth.sv
// Synthetic P300 generator: on trigger, emits baseline latency, linear rise,
// peak hold and linear decay as an 8-bit sample stream paced by a divider.
module eeg_p300_synth
    import eeg_pkg::*;
#(
    parameter int DIV      = 4,
    parameter int BASELINE = BASELINE_DEF,
    parameter int PEAK_AMP = 90,
    parameter int STEP     = 5,
    parameter int LATENCY  = 60,
    parameter int HOLD     = 8
) (
    input  logic               clk,
    input  logic               reset,
    eeg_p300_synth_if.slave    bus
);
    localparam logic [7:0]  BASE_L    = 8'(BASELINE);
    localparam logic [7:0]  PEAK_L    = 8'(PEAK_AMP);
    localparam logic [8:0]  STEP_L    = 9'(STEP);
    localparam logic [15:0] LAT_LAST  = 16'(LATENCY - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  eeg_q, eeg_d;
    logic        valid_q;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        accept;
    logic        tick;

    // Acceptance realigns the divider so tick k lands exactly k*DIV cycles later.
    eeg_sample_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        eeg_d   = eeg_q;
        done_d  = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                eeg_d = BASE_L;
                if (bus.trigger) begin
                    accept  = 1'b1;
                    state_d = ST_LAT;
                    cnt_d   = '0;
                end
            end
            ST_LAT: begin
                if (tick) begin
                    if (cnt_q == LAT_LAST) begin
                        state_d = ST_RISE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_RISE: begin
                if (tick) begin
                    eeg_d = sat_add(eeg_q, STEP_L, PEAK_L);
                    if (eeg_d == PEAK_L) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
            end
            ST_HOLD: begin
                eeg_d = PEAK_L;
                if (tick) begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_FALL;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_FALL: begin
                if (tick) begin
                    eeg_d = sat_sub(eeg_q, STEP_L, BASE_L);
                    if (eeg_d == BASE_L) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                eeg_d   = BASE_L;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            eeg_q   <= BASE_L;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            eeg_q   <= eeg_d;
            valid_q <= tick;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.eeg_signal   = eeg_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_eeg_p300_synth.sv
// Directed bench for eeg_p300_synth: defaults, fast saturating ramps, reset
// mid-waveform and back-to-back triggering, with hand-computed expectations.
module tb_eeg_p300_synth;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    eeg_p300_synth_if bus_def ();
    eeg_p300_synth_if bus_s7 ();
    eeg_p300_synth_if bus_big ();

    eeg_p300_synth u_dut (.clk(clk), .reset(rst), .bus(bus_def));

    eeg_p300_synth #(.DIV(1), .STEP(7), .LATENCY(3), .HOLD(2)) u_s7 (
        .clk(clk), .reset(rst), .bus(bus_s7));

    eeg_p300_synth #(.DIV(1), .PEAK_AMP(255), .STEP(200), .LATENCY(2), .HOLD(2)) u_big (
        .clk(clk), .reset(rst), .bus(bus_big));

    // Expected default-parameter sample for tick k (k >= 1).
    function automatic int exp_default(input int k);
        if (k <= 60) return 50;
        if (k <= 68) return 50 + 5 * (k - 60);
        if (k <= 76) return 90;
        if (k <= 84) return 90 - 5 * (k - 76);
        return 50;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus_def.trigger = 1'b0;
        bus_s7.trigger  = 1'b0;
        bus_big.trigger = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus_def.eeg_signal !== 8'd50) begin
            failures++; $display("FAIL reset_eeg got %0d want 50", bus_def.eeg_signal);
        end
        checks++;
        if ({bus_def.sample_valid, bus_def.busy, bus_def.done} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got %b want 000",
                                 {bus_def.sample_valid, bus_def.busy, bus_def.done});
        end
        checks++;
        if ({bus_s7.sample_valid, bus_big.sample_valid, bus_big.busy} !== 3'b000) begin
            failures++; $display("FAIL reset_flags_alt got %b want 000",
                                 {bus_s7.sample_valid, bus_big.sample_valid, bus_big.busy});
        end
        checks++;
        if (bus_big.eeg_signal !== 8'd50) begin
            failures++; $display("FAIL reset_eeg_big got %0d want 50", bus_big.eeg_signal);
        end
        rst = 1'b0;
        repeat (5) @(posedge clk);
        $display("test_reset done");
    endtask

    task automatic test_default_waveform();
        int exp_eeg;
        @(posedge clk); #1 bus_def.trigger = 1'b1;
        @(posedge clk); #1 bus_def.trigger = 1'b0;
        checks++;
        if (bus_def.busy !== 1'b1) begin
            failures++; $display("FAIL accept_busy got %b want 1", bus_def.busy);
        end
        exp_eeg = 50;
        for (int n = 1; n <= 336; n++) begin
            @(posedge clk); #1;
            if (n % 4 == 0) exp_eeg = exp_default(n / 4);
            checks++;
            if (bus_def.eeg_signal !== 8'(exp_eeg)) begin
                failures++; $display("FAIL def_eeg cyc=%0d got %0d want %0d", n,
                                     bus_def.eeg_signal, exp_eeg);
            end
            checks++;
            if (bus_def.sample_valid !== (n % 4 == 0)) begin
                failures++; $display("FAIL def_valid cyc=%0d got %b want %b", n,
                                     bus_def.sample_valid, (n % 4 == 0));
            end
            checks++;
            if (bus_def.busy !== (n < 336)) begin
                failures++; $display("FAIL def_busy cyc=%0d got %b want %b", n,
                                     bus_def.busy, (n < 336));
            end
            checks++;
            if (bus_def.done !== (n == 336)) begin
                failures++; $display("FAIL def_done cyc=%0d got %b want %b", n,
                                     bus_def.done, (n == 336));
            end
        end
        @(posedge clk); #1;
        checks++;
        if (bus_def.done !== 1'b0) begin
            failures++; $display("FAIL def_done_width got %b want 0", bus_def.done);
        end
        $display("test_default_waveform done");
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1 bus_def.trigger = 1'b1;
        @(posedge clk); #1 bus_def.trigger = 1'b0;
        repeat (279) @(posedge clk);
        #1;
        checks++;
        if (bus_def.eeg_signal !== 8'd90) begin
            failures++; $display("FAIL mid_hold_eeg got %0d want 90", bus_def.eeg_signal);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus_def.eeg_signal !== 8'd50) begin
            failures++; $display("FAIL mid_reset_eeg got %0d want 50", bus_def.eeg_signal);
        end
        checks++;
        if ({bus_def.busy, bus_def.done, bus_def.sample_valid} !== 3'b000) begin
            failures++; $display("FAIL mid_reset_flags got %b want 000",
                                 {bus_def.busy, bus_def.done, bus_def.sample_valid});
        end
        rst = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus_def.busy, bus_def.done} !== 2'b00 || bus_def.eeg_signal !== 8'd50) begin
                failures++; $display("FAIL mid_after got busy=%b done=%b eeg=%0d want 0 0 50",
                                     bus_def.busy, bus_def.done, bus_def.eeg_signal);
            end
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_step7();
        int exp7 [17] = '{50, 50, 50, 57, 64, 71, 78, 85, 90, 90, 90, 83, 76, 69, 62, 55, 50};
        @(posedge clk); #1 bus_s7.trigger = 1'b1;
        @(posedge clk); #1 bus_s7.trigger = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            @(posedge clk); #1;
            checks++;
            if (bus_s7.eeg_signal !== 8'(exp7[n-1]) || bus_s7.sample_valid !== 1'b1) begin
                failures++; $display("FAIL s7_eeg tick=%0d got %0d/%b want %0d/1", n,
                                     bus_s7.eeg_signal, bus_s7.sample_valid, exp7[n-1]);
            end
            checks++;
            if (bus_s7.done !== (n == 17) || bus_s7.busy !== (n < 17)) begin
                failures++; $display("FAIL s7_ctl tick=%0d got done=%b busy=%b", n,
                                     bus_s7.done, bus_s7.busy);
            end
        end
        $display("test_step7 done");
    endtask

    task automatic test_big();
        int expb [8] = '{50, 50, 250, 255, 255, 255, 55, 50};
        @(posedge clk); #1 bus_big.trigger = 1'b1;
        @(posedge clk); #1 bus_big.trigger = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            checks++;
            if (bus_big.eeg_signal !== 8'(expb[n-1])) begin
                failures++; $display("FAIL big_eeg tick=%0d got %0d want %0d", n,
                                     bus_big.eeg_signal, expb[n-1]);
            end
            checks++;
            if (bus_big.done !== (n == 8)) begin
                failures++; $display("FAIL big_done tick=%0d got %b want %b", n,
                                     bus_big.done, (n == 8));
            end
        end
        $display("test_big done");
    endtask

    task automatic test_back_to_back();
        int done_cnt;
        done_cnt = 0;
        @(posedge clk); #1 bus_def.trigger = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 336; n++) begin
            @(posedge clk); #1;
            if (bus_def.done === 1'b1) done_cnt++;
            if (n == 336) begin
                checks++;
                if (bus_def.done !== 1'b1 || bus_def.busy !== 1'b0) begin
                    failures++; $display("FAIL b2b_first_end got done=%b busy=%b want 1 0",
                                         bus_def.done, bus_def.busy);
                end
            end
        end
        checks++;
        if (done_cnt != 1) begin
            failures++; $display("FAIL b2b_single got %0d done pulses want 1", done_cnt);
        end
        @(posedge clk); #1;
        bus_def.trigger = 1'b0;
        checks++;
        if (bus_def.busy !== 1'b1 || bus_def.done !== 1'b0) begin
            failures++; $display("FAIL b2b_restart got busy=%b done=%b want 1 0",
                                 bus_def.busy, bus_def.done);
        end
        for (int n = 338; n <= 674; n++) begin
            @(posedge clk); #1;
            if (n == 581) begin
                checks++;
                if (bus_def.eeg_signal !== 8'd55) begin
                    failures++; $display("FAIL b2b_rise got %0d want 55", bus_def.eeg_signal);
                end
            end
            if (n == 673) begin
                checks++;
                if (bus_def.done !== 1'b1) begin
                    failures++; $display("FAIL b2b_second_done got %b want 1", bus_def.done);
                end
            end
            if (n == 674) begin
                checks++;
                if (bus_def.busy !== 1'b0 || bus_def.eeg_signal !== 8'd50) begin
                    failures++; $display("FAIL b2b_idle got busy=%b eeg=%0d want 0 50",
                                         bus_def.busy, bus_def.eeg_signal);
                end
            end
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_default_waveform();
        test_reset_mid();
        test_step7();
        test_big();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
